pc_fetch_unit: RTL and testbench

Instruction fetch stage for picoMips. It sits directly upstream of the synchronous program ROM: it generates the ROM address and gates each returned instruction into the datapath with a valid strobe. It owns the program counter, wrap-around at end of program, and the HEI (halt-if-equal-immediate) stall, evaluated against a synchronised, debounced SW8.

---
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - picoMips fetch stage: PC, ROM addressing, wrap, HEI stall on debounced SW8
module pc_fetch_unit #(
  parameter int          ADDR_W          = 5,
  parameter int          PROG_LEN        = 28,
  parameter logic [5:0]  HEI_OPCODE      = 6'b000111,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Sw8,
  input  logic [9:0]        Instruction,
  output logic [ADDR_W-1:0] Addr,
  output logic              InstrValid,
  output logic              Waiting,
  output logic              WrapPulse,
  output logic              Sw8Db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {PRIME, EXEC, WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_pc, cur_pc_nxt, nxt;
  logic              sw_meta, sw_sync;
  logic [CNT_W-1:0]  cnt;
  logic              hei, hold, pass;
  logic              unused_imm_bits;

  assign unused_imm_bits = ^Instruction[3:1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= Sw8;
      sw_sync <= sw_meta;
    end
  end

  // The debounced value only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      Sw8Db <= 1'b0;
    end else if (sw_sync == Sw8Db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      Sw8Db <= sw_sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hei  = (Instruction[9:4] == HEI_OPCODE);
  assign hold = hei & (Sw8Db == Instruction[0]);
  assign nxt  = (cur_pc == LAST_PC) ? '0 : cur_pc + 1'b1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= PRIME;
      cur_pc <= '0;
    end else begin
      state  <= state_nxt;
      cur_pc <= cur_pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cur_pc_nxt = cur_pc;
    Addr       = '0;
    InstrValid = 1'b0;
    Waiting    = 1'b0;
    pass       = 1'b0;
    case (state)
      PRIME: begin
        state_nxt  = EXEC;
        cur_pc_nxt = '0;
      end
      EXEC, WAIT: begin
        // A stalled HEI keeps re-reading its own address so the ROM word stays presented.
        if (hold) begin
          Addr      = cur_pc;
          Waiting   = 1'b1;
          state_nxt = WAIT;
        end else begin
          pass       = 1'b1;
          InstrValid = 1'b1;
          Addr       = nxt;
          cur_pc_nxt = nxt;
          state_nxt  = EXEC;
        end
      end
      default: begin
        state_nxt  = PRIME;
        cur_pc_nxt = '0;
      end
    endcase
  end

  assign WrapPulse = pass & (cur_pc == LAST_PC);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed bench for pc_fetch_unit with a synchronous ROM model
module tb_pc_fetch_unit;

  logic       Clock;
  logic       Reset;
  logic       Sw8;
  logic [9:0] Instruction;
  logic [4:0] Addr;
  logic       InstrValid;
  logic       Waiting;
  logic       WrapPulse;
  logic       Sw8Db;

  logic [9:0] rom [0:27];
  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .Sw8(Sw8), .Instruction(Instruction),
    .Addr(Addr), .InstrValid(InstrValid), .Waiting(Waiting),
    .WrapPulse(WrapPulse), .Sw8Db(Sw8Db)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) Instruction <= rom[Addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_plain_rom();
    for (int i = 0; i < 28; i++) rom[i] = {6'h20 | 6'(i), 4'h5};
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_addr", 32'(Addr), 0);
    check("rst_valid", 32'(InstrValid), 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("prime_valid", 32'(InstrValid), 0);
    check("prime_addr", 32'(Addr), 0);
    check("prime_wait", 32'(Waiting), 0);
  endtask

  initial begin
    Reset = 1'b1;
    Sw8   = 1'b0;
    load_plain_rom();
    #2;
    check("async_rst_addr", 32'(Addr), 0);
    check("async_rst_wrap", 32'(WrapPulse), 0);
    check("async_rst_db", 32'(Sw8Db), 0);

    // Free run through the whole program and across the wrap.
    do_reset();
    for (int n = 0; n < 28; n++) begin
      @(negedge Clock);
      check("run_valid", 32'(InstrValid), 1);
      check("run_instr", 32'(Instruction), 32'(rom[n]));
      check("run_addr", 32'(Addr), (n == 27) ? 0 : n + 1);
      check("run_wrap", 32'(WrapPulse), (n == 27) ? 1 : 0);
      check("run_wait", 32'(Waiting), 0);
    end
    @(negedge Clock);
    check("wrap_instr0", 32'(Instruction), 32'(rom[0]));
    check("wrap_valid", 32'(InstrValid), 1);
    check("wrap_addr", 32'(Addr), 1);
    check("wrap_pulse_off", 32'(WrapPulse), 0);

    // HEI imm 0 at address 0, released by a clean Sw8 rise.
    rom[0] = {6'b000111, 4'b0000};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("hei0_wait", 32'(Waiting), 1);
      check("hei0_addr", 32'(Addr), 0);
      check("hei0_valid", 32'(InstrValid), 0);
    end
    Sw8 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      if (k < 6) begin
        check("hei0_still_wait", 32'(Waiting), 1);
        check("hei0_db_low", 32'(Sw8Db), 0);
      end else begin
        check("hei0_release_wait", 32'(Waiting), 0);
        check("hei0_release_valid", 32'(InstrValid), 1);
        check("hei0_release_addr", 32'(Addr), 1);
        check("hei0_release_db", 32'(Sw8Db), 1);
      end
    end
    @(negedge Clock);
    check("hei0_next_instr", 32'(Instruction), 32'(rom[1]));
    check("hei0_next_valid", 32'(InstrValid), 1);

    // Glitch rejection: 3 cycles high is ignored, 4 cycles high releases.
    Sw8 = 1'b0;
    do_reset();
    @(negedge Clock);
    check("glitch_wait_start", 32'(Waiting), 1);
    Sw8 = 1'b1;
    repeat (3) @(negedge Clock);
    Sw8 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      check("glitch_db", 32'(Sw8Db), 0);
      check("glitch_wait", 32'(Waiting), 1);
      check("glitch_addr", 32'(Addr), 0);
    end
    Sw8 = 1'b1;
    repeat (4) @(negedge Clock);
    Sw8 = 1'b0;
    @(negedge Clock);
    check("long_pulse_wait", 32'(Waiting), 1);
    @(negedge Clock);
    check("long_pulse_release", 32'(Waiting), 0);
    check("long_pulse_valid", 32'(InstrValid), 1);
    check("long_pulse_db", 32'(Sw8Db), 1);

    // HEI imm 1 with Sw8Db already 0 passes in a single cycle.
    load_plain_rom();
    rom[2] = {6'b000111, 4'b0001};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      @(negedge Clock);
      check("hei1_valid", 32'(InstrValid), 1);
      check("hei1_wait", 32'(Waiting), 0);
      check("hei1_addr", 32'(Addr), n + 1);
    end

    // Stall at address 7 on HEI imm 1 (Sw8Db high), then reset asynchronously mid-wait.
    load_plain_rom();
    rom[7] = {6'b000111, 4'b0001};
    Sw8 = 1'b1;
    do_reset();
    repeat (8) @(negedge Clock);
    check("mid_wait_db", 32'(Sw8Db), 1);
    check("mid_wait_wait", 32'(Waiting), 1);
    check("mid_wait_addr", 32'(Addr), 7);
    repeat (2) @(negedge Clock);
    check("mid_wait_hold", 32'(Waiting), 1);
    #2;
    Reset = 1'b1;
    Sw8   = 1'b0;
    #1;
    check("midrst_addr", 32'(Addr), 0);
    check("midrst_wait", 32'(Waiting), 0);
    check("midrst_db", 32'(Sw8Db), 0);
    check("midrst_valid", 32'(InstrValid), 0);
    check("midrst_wrap", 32'(WrapPulse), 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("midrst_prime_valid", 32'(InstrValid), 0);
    check("midrst_prime_addr", 32'(Addr), 0);
    @(negedge Clock);
    check("midrst_first_valid", 32'(InstrValid), 1);
    check("midrst_first_instr", 32'(Instruction), 32'(rom[0]));
    check("midrst_first_addr", 32'(Addr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
